// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared code widths, special codes and glyph patterns for the seven-segment driver
package seven_seg_pkg;
  localparam int CODE_W = 5;
  localparam logic [CODE_W-1:0] CODE_DASH = 5'd16;
  localparam logic [CODE_W-1:0] CODE_BLANK = 5'd17;
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b1111110;
  localparam logic [15:0][6:0] GLYPHS = {
    7'b0111000, 7'b0010000, 7'b1000010, 7'b0110001,
    7'b1100000, 7'b0000010, 7'b0000100, 7'b0000000,
    7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
    7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };
endpackage

// File: rtl/seven_seg_glyph.sv
// seven_seg_glyph: 5-bit glyph code to active-low segment pattern (a..g = bit6..bit0)
module seven_seg_glyph
  import seven_seg_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [6:0]        seg
);
  always_comb seg = !code[4] ? GLYPHS[code[3:0]] : code == CODE_DASH ? SEG_DASH : SEG_OFF;
endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: multiplexed N-digit common-anode driver with dead-time, blink, blank, LZ suppression and frame-aligned load
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYC    = 2,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_req,
  output logic                         load_ack,
  input  logic [CODE_W*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]        blank_in,
  input  logic [NUM_DIGITS-1:0]        blink_in,
  input  logic                         lz_en,
  output logic [6:0]                   seg_out,
  output logic [NUM_DIGITS-1:0]        an_out,
  output logic                         frame_start
);
  localparam int SW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  logic [SW-1:0] slot_q, slot_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic phase_q, phase_d;
  logic [CODE_W-1:0] code_q [NUM_DIGITS];
  logic [CODE_W-1:0] code_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blank_q, blank_d, blink_q, blink_d, an_q, an_d, sup;
  logic [6:0] seg_q, seg_d, glyph_seg;
  logic ack_q, ack_d, frame_q, frame_d, slot_end, bound, load, bend, zero_above;
  seven_seg_glyph u_glyph (.code(code_q[idx_q]), .seg(glyph_seg));
  always_comb begin
    slot_end = slot_q == SW'(REFRESH_DIV - 1);
    bound = slot_end && idx_q == IW'(NUM_DIGITS - 1);
    slot_d = slot_end ? '0 : slot_q + 1'b1;
    idx_d = bound ? '0 : slot_end ? idx_q + 1'b1 : idx_q;
    bend = bcnt_q == BW'(BLINK_DIV - 1);
    bcnt_d = bend ? '0 : bcnt_q + 1'b1;
    phase_d = phase_q ^ bend;
    load = bound & load_req;
    ack_d = load;
    frame_d = bound;
    blank_d = load ? blank_in : blank_q;
    blink_d = load ? blink_in : blink_q;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      code_d[i] = load ? digits_in[i*CODE_W +: CODE_W] : code_q[i];
      zero_above = zero_above & (code_q[i] == '0);
      sup[i] = zero_above & (i != 0);
    end
    an_d = slot_q < SW'(DEAD_CYC) ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    seg_d = blank_q[idx_q] | (blink_q[idx_q] & phase_q) | (lz_en & sup[idx_q]) ? SEG_OFF : glyph_seg;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
      idx_q <= '0;
      bcnt_q <= '0;
      phase_q <= 1'b0;
      code_q <= '{default: '0};
      blank_q <= '1;
      blink_q <= '0;
      an_q <= '1;
      seg_q <= SEG_OFF;
      ack_q <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      idx_q <= idx_d;
      bcnt_q <= bcnt_d;
      phase_q <= phase_d;
      code_q <= code_d;
      blank_q <= blank_d;
      blink_q <= blink_d;
      an_q <= an_d;
      seg_q <= seg_d;
      ack_q <= ack_d;
      frame_q <= frame_d;
    end
  end
  assign seg_out = seg_q;
  assign an_out = an_q;
  assign load_ack = ack_q;
  assign frame_start = frame_q;
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: table-driven frame checks plus handshake, blink and reset corner sequences
module tb_seven_seg_scan;
  logic clk, rst, load_req, load_ack, lz_en, frame_start;
  logic [19:0] digits_in;
  logic [3:0] blank_in, blink_in, an_out;
  logic [6:0] seg_out;
  int t, total, passed;
  logic [6:0] seg_a [64];
  logic [3:0] an_a [64];
  logic ack_a [64];
  int ts [64];
  typedef struct {
    logic [19:0] dig;
    logic [3:0]  blank;
    logic        lz;
    logic [27:0] exp;
  } vec_t;
  vec_t v [8];
  seven_seg_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYC(1), .BLINK_DIV(32)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .load_ack(load_ack), .digits_in(digits_in),
    .blank_in(blank_in), .blink_in(blink_in), .lz_en(lz_en), .seg_out(seg_out),
    .an_out(an_out), .frame_start(frame_start)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    t = 0;
  endtask
  task automatic wait_frame(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_start && n < 40);
    chk("frame_timeout", 32'(frame_start), 1);
  endtask
  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      seg_a[k] = seg_out;
      an_a[k] = an_out;
      ack_a[k] = load_ack;
      ts[k] = t - 1;
    end
  endtask
  task automatic check_frame(input string nm, input logic [27:0] exp);
    logic [3:0] ea;
    for (int i = 0; i < 4; i++) begin
      ea = ~(4'b0001 << i);
      chk($sformatf("%s_dead_an%0d", nm, i), 32'(an_a[4*i]), 32'hF);
      chk($sformatf("%s_dead_seg%0d", nm, i), 32'(seg_a[4*i]), 32'(exp[i*7 +: 7]));
      chk($sformatf("%s_an%0d", nm, i), 32'(an_a[4*i+1]), 32'(ea));
      chk($sformatf("%s_seg%0d", nm, i), 32'(seg_a[4*i+1]), 32'(exp[i*7 +: 7]));
    end
  endtask
  task automatic load(input logic [19:0] dig, input logic [3:0] blank, input logic [3:0] blink, input logic lz);
    int n;
    digits_in = dig;
    blank_in = blank;
    blink_in = blink;
    lz_en = lz;
    load_req = 1'b1;
    wait_frame(n);
    chk("load_ack", 32'(load_ack), 1);
    load_req = 1'b0;
  endtask
  initial begin
    int n;
    logic [6:0] e;
    total = 0;
    passed = 0;
    t = 0;
    load_req = 1'b0;
    digits_in = '0;
    blank_in = '0;
    blink_in = '0;
    lz_en = 1'b0;
    v[0] = '{{5'd1, 5'd2, 5'd10, 5'd4}, 4'b0000, 1'b0, {7'b1001111, 7'b0010010, 7'b0000010, 7'b1001100}};
    v[1] = '{{5'd0, 5'd0, 5'd7, 5'd0}, 4'b0000, 1'b1, {7'b1111111, 7'b1111111, 7'b0001111, 7'b0000001}};
    v[2] = '{{5'd0, 5'd0, 5'd7, 5'd0}, 4'b0000, 1'b0, {7'b0000001, 7'b0000001, 7'b0001111, 7'b0000001}};
    v[3] = '{{5'd8, 5'd8, 5'd20, 5'd16}, 4'b0100, 1'b0, {7'b0000000, 7'b1111111, 7'b1111111, 7'b1111110}};
    v[4] = '{{5'd15, 5'd14, 5'd13, 5'd12}, 4'b0000, 1'b1, {7'b0111000, 7'b0010000, 7'b1000010, 7'b0110001}};
    v[5] = '{{5'd11, 5'd9, 5'd6, 5'd3}, 4'b0000, 1'b0, {7'b1100000, 7'b0000100, 7'b0100000, 7'b0000110}};
    v[6] = '{{5'd0, 5'd5, 5'd0, 5'd0}, 4'b0000, 1'b1, {7'b1111111, 7'b0100100, 7'b0000001, 7'b0000001}};
    v[7] = '{{5'd0, 5'd0, 5'd0, 5'd0}, 4'b0000, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}};
    do_reset();
    chk("rst_seg", 32'(seg_out), 32'h7F);
    chk("rst_an", 32'(an_out), 32'hF);
    chk("rst_ack", 32'(load_ack), 0);
    chk("rst_frame", 32'(frame_start), 0);
    wait_frame(n);
    chk("first_frame_delay", n, 16);
    chk("no_req_ack", 32'(load_ack), 0);
    for (int k = 0; k < 8; k++) begin
      load(v[k].dig, v[k].blank, 4'b0000, v[k].lz);
      capture(16);
      chk($sformatf("v%0d_ack_drop", k), 32'(ack_a[0]), 0);
      check_frame($sformatf("v%0d", k), v[k].exp);
    end
    repeat (3) tick();
    digits_in = {5'd8, 5'd8, 5'd8, 5'd8};
    lz_en = 1'b1;
    load_req = 1'b1;
    tick();
    chk("pulse_ack0", 32'(load_ack), 0);
    tick();
    chk("pulse_ack1", 32'(load_ack), 0);
    load_req = 1'b0;
    wait_frame(n);
    chk("pulse_boundary_ack", 32'(load_ack), 0);
    capture(16);
    check_frame("pulse_unchanged", v[7].exp);
    load({5'd8, 5'd5, 5'd8, 5'd8}, 4'b0000, 4'b0100, 1'b0);
    capture(64);
    for (int f = 0; f < 4; f++) begin
      e = ((ts[16*f+9] / 32) % 2) != 0 ? 7'b1111111 : 7'b0100100;
      chk($sformatf("blink_d2_f%0d", f), 32'(seg_a[16*f+9]), 32'(e));
      chk($sformatf("blink_d1_f%0d", f), 32'(seg_a[16*f+5]), 32'h00);
    end
    load_req = 1'b1;
    digits_in = {5'd1, 5'd1, 5'd1, 5'd1};
    blank_in = 4'b0000;
    blink_in = 4'b0000;
    repeat (3) tick();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    load_req = 1'b0;
    t = 0;
    tick();
    chk("mid_rst_seg", 32'(seg_out), 32'h7F);
    chk("mid_rst_an", 32'(an_out), 32'hF);
    chk("mid_rst_ack", 32'(load_ack), 0);
    wait_frame(n);
    chk("mid_rst_boundary_ack", 32'(load_ack), 0);
    capture(16);
    check_frame("mid_rst_dark", {4{7'b1111111}});
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
